// File: rtl/sram_stage_sequencer_if.sv
// Purpose: wiring bundle between the stage sequencer, its stage clients, the idle client and the SRAM port.
// Latency: none; this is wiring only.
// Backpressure: none on this bundle; stage_done is the only completion signal.
interface sram_stage_sequencer_if #(
    parameter int N_STAGES = 3,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16
);
    // run control
    logic                         go;
    logic                         abort;
    logic [N_STAGES-1:0]          stage_enable;
    logic                         busy;
    logic                         seq_done;
    logic                         timeout_error;

    // stage handshakes and stage-side SRAM requests
    logic [N_STAGES-1:0]          stage_start;
    logic [N_STAGES-1:0]          stage_done;
    logic [N_STAGES*ADDR_W-1:0]   stage_addr;
    logic [N_STAGES*DATA_W-1:0]   stage_wdata;
    logic [N_STAGES-1:0]          stage_we_n;
    logic [N_STAGES-1:0]          active_stage;

    // idle (read-only) client
    logic [ADDR_W-1:0]            idle_addr;
    logic                         idle_enable;

    // SRAM controller side
    logic [ADDR_W-1:0]            SRAM_address;
    logic [DATA_W-1:0]            SRAM_write_data;
    logic                         SRAM_we_n;

    // Sequencer side of the bundle.
    modport slave (
        input  go, abort, stage_enable, stage_done, stage_addr, stage_wdata, stage_we_n, idle_addr,
        output stage_start, idle_enable, SRAM_address, SRAM_write_data, SRAM_we_n,
               busy, active_stage, seq_done, timeout_error
    );

    // Client / environment side of the bundle.
    modport master (
        output go, abort, stage_enable, stage_done, stage_addr, stage_wdata, stage_we_n, idle_addr,
        input  stage_start, idle_enable, SRAM_address, SRAM_write_data, SRAM_we_n,
               busy, active_stage, seq_done, timeout_error
    );
endinterface

// File: rtl/sram_stage_sequencer.sv
// Purpose: runs enabled stages in ascending order via start/done; the running stage owns the SRAM port.
// Latency: go -> first stage_start 1 cycle; done -> next start 1 cycle; SRAM mux is combinational (0 cycles).
// Backpressure: a stage holds the sequencer in S_WAIT until done, watchdog timeout or abort.
module sram_stage_sequencer #(
    parameter int               N_STAGES   = 3,
    parameter int               ADDR_W     = 18,
    parameter int               DATA_W     = 16,
    parameter int               TMO_W      = 26,
    parameter logic [TMO_W-1:0] TMO_CYCLES = 26'd49999999
) (
    input  logic                 clock,
    input  logic                 resetn,
    sram_stage_sequencer_if.slave bus
);

    localparam int               CUR_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    // The watchdog is compared against the last legal count so the limit
    // lands exactly TMO_CYCLES cycles after the start pulse.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_CYCLES - 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CUR_W-1:0]    cur_q,   cur_d;
    logic [N_STAGES-1:0] en_q,    en_d;
    logic [TMO_W-1:0]    wd_q,    wd_d;
    logic                tmo_q,   tmo_d;

    logic                first_vld;
    logic [CUR_W-1:0]    first_idx;
    logic                next_vld;
    logic [CUR_W-1:0]    next_idx;
    logic                done_cur;
    logic                owns;
    logic [N_STAGES-1:0] cur_onehot;

    // Lowest enabled stage in the incoming mask (the first stage of a new run).
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            if (bus.stage_enable[k]) begin
                first_vld = 1'b1;
                first_idx = CUR_W'(k);
            end
        end
    end

    // Lowest enabled stage strictly above the current one (the successor).
    always_comb begin
        next_vld = 1'b0;
        next_idx = '0;
        for (int k = N_STAGES - 1; k >= 0; k--) begin
            if (en_q[k] && (k > int'(cur_q))) begin
                next_vld = 1'b1;
                next_idx = CUR_W'(k);
            end
        end
    end

    // Only the current stage's done bit is ever looked at.
    assign done_cur = bus.stage_done[cur_q];

    // Next-state logic: abort first, then done, then the watchdog limit.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        en_d    = en_q;
        wd_d    = wd_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    en_d  = bus.stage_enable;
                    tmo_d = 1'b0;
                    if (first_vld) begin
                        cur_d   = first_idx;
                        state_d = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_START: begin
                wd_d    = '0;
                state_d = bus.abort ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (bus.abort) begin
                    state_d = S_DONE;
                end else if (done_cur) begin
                    if (next_vld) begin
                        cur_d   = next_idx;
                        state_d = S_START;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (wd_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, stage index, latched mask, watchdog and sticky timeout flag.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            en_q    <= '0;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            en_q    <= en_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
        end
    end

    // Control outputs are decoded straight from registered state.
    assign owns       = (state_q == S_START) || (state_q == S_WAIT);
    assign cur_onehot = N_STAGES'(1) << cur_q;

    assign bus.busy          = (state_q != S_IDLE);
    assign bus.seq_done      = (state_q == S_DONE);
    assign bus.idle_enable   = !owns;
    assign bus.stage_start   = (state_q == S_START) ? cur_onehot : '0;
    assign bus.active_stage  = owns ? cur_onehot : '0;
    assign bus.timeout_error = tmo_q;

    // SRAM port mux; the idle client is read-only so its write path is parked.
    assign bus.SRAM_address    = owns ? bus.stage_addr[cur_q*ADDR_W +: ADDR_W]  : bus.idle_addr;
    assign bus.SRAM_write_data = owns ? bus.stage_wdata[cur_q*DATA_W +: DATA_W] : '0;
    assign bus.SRAM_we_n       = owns ? bus.stage_we_n[cur_q]                   : 1'b1;

    // Ownership is never shared, and a write can only come from the owner.
    a_owner_onehot: assert property (@(posedge clock) disable iff (!resetn)
        $onehot0(bus.active_stage));
    a_no_stray_write: assert property (@(posedge clock) disable iff (!resetn)
        !owns |-> bus.SRAM_we_n);
    a_start_single: assert property (@(posedge clock) disable iff (!resetn)
        (bus.stage_start != '0) |=> (bus.stage_start == '0));

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Purpose: randomized and directed check of the stage sequencer against a per-run schedule model.
// Latency: expected event cycles are derived from go/done/abort/timeout timing rules.
// Backpressure: stage clients answer each observed start after a chosen delay (or never).
module tb_sram_stage_sequencer;
    localparam int N    = 3;
    localparam int AW   = 18;
    localparam int DW   = 16;
    localparam int TMO  = 100;
    localparam int MAXR = 512;

    logic clock  = 1'b0;
    logic resetn = 1'b1;
    always #10 clock = ~clock;

    sram_stage_sequencer_if #(.N_STAGES(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_stage_sequencer #(
        .N_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .TMO_W(26), .TMO_CYCLES(26'd100)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Per-run schedule: owner per relative cycle (-1 = idle client) and start pulses.
    int           exp_owner [MAXR];
    logic [N-1:0] exp_start [MAXR];
    bit           err_prev = 1'b0;

    logic [AW-1:0] av [N];
    logic [DW-1:0] dv [N];
    logic [N-1:0]  wev;
    logic [AW-1:0] iav;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic drive_data(input int ovr);
        for (int k = 0; k < N; k++) begin
            av[k]  = AW'($urandom);
            dv[k]  = DW'($urandom);
            wev[k] = 1'($urandom);
        end
        if (ovr == 1) begin
            av[1] = 18'd146944; dv[1] = 16'hBEEF; wev[1] = 1'b0;
        end else if (ovr == 2) begin
            av[1] = 18'h3FFFF; wev[1] = 1'b0;
        end
        iav = AW'($urandom);
        for (int k = 0; k < N; k++) begin
            bus.stage_addr[k*AW +: AW]  = av[k];
            bus.stage_wdata[k*DW +: DW] = dv[k];
        end
        bus.stage_we_n = wev;
        bus.idle_addr  = iav;
    endtask

    // One run: go at relative cycle 0, stage k answers its start after dly[k] cycles.
    task automatic run_seq(input logic [N-1:0] mask, input int d0, input int d1, input int d2,
                           input int abort_r, input int lvl, input int ovr, input bit noise);
        int dly [N];
        int dn_at [N];
        int s;
        int endr;
        bit ended;
        bit tmo;
        int own;
        dly = '{d0, d1, d2};
        for (int r = 0; r < MAXR; r++) begin
            exp_owner[r] = -1;
            exp_start[r] = '0;
        end
        s = 1; endr = 1; ended = 1'b0; tmo = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (mask[k] && !ended) begin
                int fin;
                bit to;
                to  = (dly[k] > TMO);
                fin = to ? s + TMO : s + dly[k];
                exp_start[s][k] = 1'b1;
                if (abort_r >= s && abort_r <= fin) begin
                    fin = abort_r; to = 1'b0; ended = 1'b1;
                end
                for (int r = s; r <= fin; r++) exp_owner[r] = k;
                endr = fin + 1;
                if (to) begin tmo = 1'b1; ended = 1'b1; end
                s = fin + 1;
            end
        end
        for (int k = 0; k < N; k++) dn_at[k] = -10000;

        for (int r = 0; r <= endr + 1; r++) begin
            own = exp_owner[r];
            bus.go           = (r == 0) ? 1'b1 : (r <= endr && noise && $urandom_range(0, 3) == 0);
            bus.stage_enable = (r == 0) ? mask : N'($urandom);
            bus.abort        = (r == abort_r) ||
                               (noise && (r == 0 || r >= endr) && $urandom_range(0, 2) == 0);
            for (int k = 0; k < N; k++) begin
                bit p;
                bit nz;
                p  = (r >= dn_at[k]) && (r < dn_at[k] + lvl);
                nz = noise && (k != own) && ($urandom_range(0, 3) == 0);
                bus.stage_done[k] = p | nz;
            end
            drive_data(ovr);

            @(negedge clock);
            chk("busy",     bus.busy,        (r >= 1 && r <= endr));
            chk("seq_done", bus.seq_done,    (r == endr));
            chk("idle_en",  bus.idle_enable, (own < 0));
            chk("start",    bus.stage_start, exp_start[r]);
            chk("active",   bus.active_stage, (own < 0) ? 0 : (1 << own));
            chk("tmo_err",  bus.timeout_error, (r == 0) ? err_prev : ((r < endr) ? 1'b0 : tmo));
            chk("sram_addr", bus.SRAM_address,    (own < 0) ? iav   : av[own]);
            chk("sram_wdat", bus.SRAM_write_data, (own < 0) ? '0    : dv[own]);
            chk("sram_we_n", bus.SRAM_we_n,       (own < 0) ? 1'b1  : wev[own]);
            // Stage clients react to the start pulse they actually receive.
            for (int k = 0; k < N; k++)
                if (bus.stage_start[k]) dn_at[k] = r + dly[k];
            tick();
        end
        err_prev = tmo;
        bus.go = 1'b0; bus.abort = 1'b0; bus.stage_done = '0;
    endtask

    initial begin
        bus.go = 1'b0; bus.abort = 1'b0; bus.stage_enable = '0; bus.stage_done = '0;
        drive_data(0);
        #1 resetn = 1'b0;

        // Reset values, checked while reset is held.
        @(negedge clock);
        chk("rst_busy",  bus.busy, 0);
        chk("rst_idle",  bus.idle_enable, 1);
        chk("rst_sd",    bus.seq_done, 0);
        chk("rst_start", bus.stage_start, 0);
        chk("rst_tmo",   bus.timeout_error, 0);
        chk("rst_act",   bus.active_stage, 0);
        chk("rst_we_n",  bus.SRAM_we_n, 1);
        chk("rst_wdat",  bus.SRAM_write_data, 0);
        chk("rst_addr",  bus.SRAM_address, iav);
        tick();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) tick();

        run_seq(3'b111, 5, 5, 5, -1, 1, 0, 1'b0);      // full run
        run_seq(3'b101, 4, 6, 3, -1, 1, 2, 1'b1);      // mask; stage 1 pushes a write nobody may see
        run_seq(3'b010, 6, 6, 6, -1, 2, 1, 1'b0);      // ownership values pass through
        run_seq(3'b111, 1000, 5, 5, -1, 1, 0, 1'b1);   // stage 0 never answers
        run_seq(3'b011, 3, TMO, 4, -1, 1, 0, 1'b1);    // done exactly at the limit wins
        run_seq(3'b111, 5, 5, 5, 6, 1, 0, 1'b1);       // abort and done collide
        run_seq(3'b111, 5, 5, 5, 1, 1, 0, 1'b0);       // abort during the first start
        run_seq(3'b000, 5, 5, 5, -1, 1, 0, 1'b1);      // empty mask

        for (int n = 0; n < 40; n++) begin
            int d [N];
            for (int k = 0; k < N; k++) begin
                int pick;
                pick = $urandom_range(0, 15);
                d[k] = (pick == 0) ? 200 : (pick == 1) ? TMO : $urandom_range(1, 8);
            end
            run_seq(N'($urandom_range(0, 7)), d[0], d[1], d[2],
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1,
                    $urandom_range(1, 3), 0, 1'b1);
        end

        // Asynchronous reset while stage 1 is writing.
        bus.stage_enable = 3'b010;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        bus.stage_we_n = 3'b101;
        tick();
        @(negedge clock);
        chk("mid_we_n", bus.SRAM_we_n, 0);
        chk("mid_busy", bus.busy, 1);
        #2 resetn = 1'b0;
        #1;
        chk("arst_we_n",  bus.SRAM_we_n, 1);
        chk("arst_busy",  bus.busy, 0);
        chk("arst_act",   bus.active_stage, 0);
        chk("arst_idle",  bus.idle_enable, 1);
        chk("arst_addr",  bus.SRAM_address, iav);
        tick();
        tick();
        resetn = 1'b1;
        @(negedge clock);
        chk("post_busy", bus.busy, 0);
        chk("post_idle", bus.idle_enable, 1);
        chk("post_sd",   bus.seq_done, 0);
        tick();
        err_prev = 1'b0;
        run_seq(3'b000, 5, 5, 5, -1, 1, 0, 1'b0);      // sequencer is back in idle
        run_seq(3'b100, 2, 2, 2, -1, 1, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
